// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with 2-flop row synchronizer, press/release debounce and key hold tracking.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000,
    parameter int unsigned REPEAT_DLY   = 500000
) (
    input  logic       iCLK,
    input  logic       nRST,
    input  logic [3:0] iROW,
    output logic [3:0] oCOL,
    output logic [3:0] oKEY,
    output logic       oVALID,
    output logic       oHELD
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CNT - 1);

    state_t      state_q;
    logic [3:0]  sync1_q, sync2_q;
    logic [1:0]  col_q, row_q;
    logic [15:0] dwell_q, cnt_q;
    logic [3:0]  key_q;
    logic        valid_q, held_q;
    logic [1:0]  low_row;
    logic        row_bit;
    logic [3:0]  rs;

    assign rs      = sync2_q;
    assign row_bit = rs[row_q];

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        low_row = 2'd3;
        if (!rs[2]) low_row = 2'd2;
        if (!rs[1]) low_row = 2'd1;
        if (!rs[0]) low_row = 2'd0;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [23:0] RPT_LAST = 24'(REPEAT_DLY - 1);
    logic [23:0] rpt_q;
`else
    // Without auto-repeat the delay parameter has no hardware behind it.
    if (REPEAT_DLY == 0) begin : g_rpt_unused
    end
`endif

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= iROW;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (rs != 4'hF) begin
                            row_q   <= low_row;
                            cnt_q   <= '0;
                            state_q <= DEBOUNCE;
                        end else begin
                            col_q <= col_q + 2'd1;
                        end
                    end else begin
                        dwell_q <= dwell_q + 16'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_bit) begin
                        if (cnt_q == DEB_LAST) begin
                            key_q   <= {row_q, col_q};
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            rpt_q   <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else begin
                        cnt_q   <= '0;
                        col_q   <= col_q + 2'd1;
                        state_q <= SCAN;
                    end
                end
                HELD: begin
                    if (row_bit) begin
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_q == RPT_LAST) begin
                        rpt_q   <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        rpt_q <= rpt_q + 24'd1;
                    end
`endif
                end
                RELEASE: begin
                    if (rs == 4'hF) begin
                        if (cnt_q == DEB_LAST) begin
                            cnt_q   <= '0;
                            held_q  <= 1'b0;
                            col_q   <= col_q + 2'd1;
                            state_q <= SCAN;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign oCOL   = ~(4'b0001 << col_q);
    assign oKEY   = key_q;
    assign oVALID = valid_q;
    assign oHELD  = held_q;
endmodule
